// File: rtl/mem_dec_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : mem_dec_streamer
//  Purpose  : Reads a block of bytes from the sample BRAM (port B) and streams
//             each one to the UART as unsigned decimal ASCII followed by LF.
//             The block ends with the "D",LF completion response.
//  Ports    : clk, rst         - clock, asynchronous active-high reset
//             start            - request pulse, honoured only when idle
//             base_addr, count - block start address and length (0..DEPTH)
//             busy, done       - block in progress / one-cycle completion
//             enb, addrb, doutb- BRAM port B read interface (1-cycle latency)
//             tx_start, tx_data, tx_busy - UART transmit handshake
//  Revision : 1.0 - initial release
// ============================================================================
module mem_dec_streamer #(
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   count,
    output logic                  busy,
    output logic                  done,
    output logic                  enb,
    output logic [ADDR_WIDTH-1:0] addrb,
    input  logic [7:0]            doutb,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    input  logic                  tx_busy
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_CAP  = 3'd2;
    localparam logic [2:0] S_SEND = 3'd3;
    localparam logic [2:0] S_TXG  = 3'd4;
    localparam logic [2:0] S_TXW  = 3'd5;
    localparam logic [2:0] S_LAST = 3'd6;
    localparam logic [2:0] S_FIN  = 3'd7;

    localparam logic [ADDR_WIDTH:0]   c_depth     = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(DEPTH-1);
    localparam logic [7:0]            c_lf        = 8'h0A;
    localparam logic [7:0]            c_ascii_0   = 8'h30;
    localparam logic [7:0]            c_ascii_d   = 8'h44;

    logic [2:0]            r_state;
    logic [2:0]            w_next_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_remain;
    logic [7:0]            r_val;
    logic [1:0]            r_idx;     // index into the active send list
    logic                  r_last;    // sending the "D",LF trailer

    logic [ADDR_WIDTH:0]   w_count_clamped;
    logic [3:0]            w_h;
    logic [3:0]            w_t;
    logic [7:0]            w_rem_h;
    logic [7:0]            w_u;
    logic [1:0]            w_skip;
    logic [1:0]            w_pos;
    logic [7:0]            w_byte;
    logic                  w_final;

    assign w_count_clamped = (count > c_depth) ? c_depth : count;

    // Decimal split by compare/subtract: hundreds first, then up to nine
    // subtractions of ten leave the units digit.
    always_comb begin
        w_h     = 4'd0;
        w_rem_h = r_val;
        if (r_val >= 8'd200) begin
            w_h     = 4'd2;
            w_rem_h = r_val - 8'd200;
        end else if (r_val >= 8'd100) begin
            w_h     = 4'd1;
            w_rem_h = r_val - 8'd100;
        end
        w_t = 4'd0;
        w_u = w_rem_h;
        for (int i = 0; i < 9; i++) begin
            if (w_u >= 8'd10) begin
                w_u = w_u - 8'd10;
                w_t = w_t + 4'd1;
            end
        end
    end

    // The full list is {h, t, u, LF}; leading zero digits are skipped by
    // starting the walk further into the list.
    assign w_skip = (w_h != 4'd0) ? 2'd0 : ((w_t != 4'd0) ? 2'd1 : 2'd2);
    assign w_pos  = r_idx + w_skip;

    always_comb begin
        w_byte  = c_lf;
        w_final = 1'b0;
        if (r_last) begin
            w_byte  = (r_idx == 2'd0) ? c_ascii_d : c_lf;
            w_final = (r_idx == 2'd1);
        end else begin
            case (w_pos)
                2'd0:    w_byte = c_ascii_0 + {4'd0, w_h};
                2'd1:    w_byte = c_ascii_0 + {4'd0, w_t};
                2'd2:    w_byte = c_ascii_0 + w_u;
                default: w_byte = c_lf;
            endcase
            w_final = (w_pos == 2'd3);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = (count == '0) ? S_LAST : S_RD;
                end
            end
            S_RD:   w_next_state = S_CAP;
            S_CAP:  w_next_state = S_SEND;
            S_SEND: begin
                if (!tx_busy) begin
                    w_next_state = S_TXG;
                end
            end
            S_TXG:  w_next_state = S_TXW;
            S_TXW: begin
                if (!tx_busy) begin
                    if (!w_final) begin
                        w_next_state = S_SEND;
                    end else if (r_last) begin
                        w_next_state = S_FIN;
                    end else if (r_remain == (ADDR_WIDTH+1)'(1)) begin
                        w_next_state = S_LAST;
                    end else begin
                        w_next_state = S_RD;
                    end
                end
            end
            S_LAST: w_next_state = S_SEND;
            S_FIN:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr   <= '0;
            r_remain <= '0;
            r_val    <= '0;
            r_idx    <= '0;
            r_last   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr   <= base_addr;
                        r_remain <= w_count_clamped;
                        r_idx    <= '0;
                        r_last   <= 1'b0;
                    end
                end
                S_CAP: begin
                    r_val <= doutb;
                    r_idx <= '0;
                end
                S_TXW: begin
                    if (!tx_busy) begin
                        if (!w_final) begin
                            r_idx <= r_idx + 2'd1;
                        end else if (!r_last) begin
                            r_addr   <= (r_addr == c_last_addr) ? '0 : r_addr + 1'b1;
                            r_remain <= r_remain - 1'b1;
                        end
                    end
                end
                S_LAST: begin
                    r_last <= 1'b1;
                    r_idx  <= '0;
                end
                default: ;
            endcase
        end
    end

    // Outputs decode straight from state so an asynchronous reset clears
    // them immediately.
    assign busy     = (r_state != S_IDLE) && (r_state != S_FIN);
    assign done     = (r_state == S_FIN);
    assign enb      = (r_state == S_RD);
    assign addrb    = r_addr;
    assign tx_start = (r_state == S_SEND) && !tx_busy;
    assign tx_data  = tx_start ? w_byte : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_mem_dec_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_dec_streamer
//  Purpose  : Directed self-checking bench for mem_dec_streamer with a BRAM
//             model and a UART busy model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_dec_streamer;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   count;
    logic          busy;
    logic          done;
    logic          enb;
    logic [AW-1:0] addrb;
    logic [7:0]    doutb = 8'h00;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          tx_busy;

    mem_dec_streamer #(.ADDR_WIDTH(AW), .DEPTH(1024)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .enb       (enb),
        .addrb     (addrb),
        .doutb     (doutb),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy)
    );

    always #5 clk = ~clk;

    // BRAM model, one-cycle read latency
    logic [7:0] mem [0:1023];
    always @(posedge clk) if (enb) doutb <= mem[addrb];

    // UART busy model: rises one cycle after tx_start, holds hold_len cycles
    logic model_busy = 1'b0;
    logic ext_busy   = 1'b0;
    int   hold_len   = 20;
    int   rise_in    = 0;
    int   hold       = 0;
    int   n_handled  = 0;
    assign tx_busy = model_busy | ext_busy;

    // Monitor (sampled mid-cycle)
    logic [7:0] tx_q [$];
    int         enb_q [$];
    int         n_tx   = 0;
    int         n_done = 0;
    int         n_viol = 0;
    logic       prev_tx = 1'b0;

    always @(negedge clk) begin
        if (tx_start) begin
            if (tx_busy) n_viol++;
            if (prev_tx) n_viol++;
            tx_q.push_back(tx_data);
            n_tx++;
        end
        prev_tx = tx_start;
        if (enb) enb_q.push_back(int'(addrb));
        if (done) n_done++;
    end

    always @(posedge clk) begin
        if (rise_in > 0) begin
            rise_in = rise_in - 1;
            if (rise_in == 0) begin
                model_busy <= 1'b1;
                hold = hold_len;
            end
        end else if (hold > 0) begin
            hold = hold - 1;
            if (hold == 0) model_busy <= 1'b0;
        end
        if (n_tx != n_handled) begin
            n_handled = n_tx;
            rise_in   = 1;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int m_tx, m_en, m_done;

    task automatic check(input string tag, input string got, input string exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got '%s' expected '%s'", tag, got, exp);
        end
    endtask

    function automatic string stream_str(input int from);
        string s = "";
        for (int i = from; i < tx_q.size(); i++)
            s = {s, (tx_q[i] == 8'h0A) ? "_" : $sformatf("%c", tx_q[i])};
        return s;
    endfunction

    function automatic string addr_str(input int from);
        string s = "";
        for (int i = from; i < enb_q.size(); i++)
            s = {s, $sformatf("%0d,", enb_q[i])};
        return s;
    endfunction

    task automatic mark();
        m_tx   = tx_q.size();
        m_en   = enb_q.size();
        m_done = n_done;
    endtask

    task automatic kick(input int b, input int c);
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = AW'(b);
        count     = (AW+1)'(c);
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int k = 0;
        while (n_done == m_done && k < limit) begin
            @(negedge clk);
            k++;
        end
        if (n_done == m_done) check(tag, "timeout", "done");
        repeat (3) @(negedge clk);
    endtask

    task automatic check_block(input string tag, input string exp_s, input string exp_a);
        check({tag, "_stream"}, stream_str(m_tx), exp_s);
        check({tag, "_addr"}, addr_str(m_en), exp_a);
        check({tag, "_done"}, $sformatf("%0d", n_done - m_done), "1");
    endtask

    initial begin
        int k;
        rst = 1'b1; start = 1'b0; base_addr = '0; count = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'd0;
        mem[0] = 8'd0; mem[1] = 8'd7; mem[2] = 8'd42; mem[3] = 8'd255;

        repeat (3) @(posedge clk);
        #2;
        check("rst_busy",     $sformatf("%0d", busy),     "0");
        check("rst_done",     $sformatf("%0d", done),     "0");
        check("rst_enb",      $sformatf("%0d", enb),      "0");
        check("rst_addrb",    $sformatf("%0d", addrb),    "0");
        check("rst_tx_start", $sformatf("%0d", tx_start), "0");
        check("rst_tx_data",  $sformatf("%0d", tx_data),  "0");
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic block of four values
        mark();
        kick(0, 4);
        wait_done("t1_wait", 5000);
        check_block("t1", "0_7_42_255_D_", "0,1,2,3,");

        // Empty block: trailer only
        mark();
        kick(0, 0);
        wait_done("t2_wait", 1000);
        check_block("t2", "D_", "");

        // Address wrap 1023 -> 0
        mem[1023] = 8'd100; mem[0] = 8'd9;
        mark();
        kick(1023, 2);
        wait_done("t3_wait", 5000);
        check_block("t3", "100_9_D_", "1023,0,");
        mem[0] = 8'd0;

        // Start while busy is ignored
        mark();
        kick(0, 2);
        repeat (30) @(posedge clk);
        check("t4_busy", $sformatf("%0d", busy), "1");
        kick(5, 3);
        wait_done("t4_wait", 5000);
        check_block("t4", "0_7_D_", "0,1,");

        // UART held busy before the first send
        mark();
        ext_busy = 1'b1;
        kick(1, 1);
        repeat (500) @(posedge clk);
        check("t5_no_tx", $sformatf("%0d", tx_q.size() - m_tx), "0");
        @(posedge clk); #1;
        ext_busy = 1'b0;
        wait_done("t5_wait", 5000);
        check_block("t5", "7_D_", "1,");

        // Asynchronous reset in the middle of the second value
        mark();
        kick(0, 4);
        k = 0;
        while (tx_q.size() - m_tx < 3 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (tx_q.size() - m_tx < 3) check("t6_wait", "timeout", "3 bytes");
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("t6_busy",     $sformatf("%0d", busy),     "0");
        check("t6_enb",      $sformatf("%0d", enb),      "0");
        check("t6_addrb",    $sformatf("%0d", addrb),    "0");
        check("t6_tx_start", $sformatf("%0d", tx_start), "0");
        check("t6_tx_data",  $sformatf("%0d", tx_data),  "0");
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        mark();
        repeat (200) @(posedge clk);
        check("t6_quiet_tx",  $sformatf("%0d", tx_q.size() - m_tx), "0");
        check("t6_quiet_enb", $sformatf("%0d", enb_q.size() - m_en), "0");
        mark();
        kick(2, 2);
        wait_done("t6_wait2", 5000);
        check_block("t6", "42_255_D_", "2,3,");

        // Oversized count clamps to DEPTH
        hold_len = 2;
        mark();
        kick(0, 2000);
        wait_done("t7_wait", 40000);
        check("t7_enb_cnt", $sformatf("%0d", enb_q.size() - m_en), "1024");
        check("t7_tx_cnt",  $sformatf("%0d", tx_q.size() - m_tx), "2055");
        check("t7_last_addr", $sformatf("%0d", enb_q[enb_q.size()-1]), "1023");
        check("t7_tail", stream_str(tx_q.size() - 6), "100_D_");
        check("t7_done", $sformatf("%0d", n_done - m_done), "1");

        check("protocol", $sformatf("%0d", n_viol), "0");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
